msrv32_machine_control: RTL and testbench

MSRV32_MACHINE_CONTROL -- requirements
Module: msrv32_machine_control

---
 rtl/msrv32_machine_control.sv | 209 ++++++++++++++++++++
 tb/tb_msrv32_machine_control.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap controller for the MSRV32 core.
// Decodes SYSTEM instructions and exception/interrupt inputs, sequences
// trap entry (TRAP_TAKEN) and MRET (TRAP_RETURN), and drives CSR strobes.
// All strobes are decoded from the state register, so they appear one cycle
// after the triggering event. instret_inc_out is the only output that also
// looks at the inputs: it is 1 only in a cycle that stays in OPERATING.
// Optional feature: define MSRV32_WFI_EN to add a WFI sleep state that
// stalls fetch until an enabled interrupt becomes pending.
module msrv32_machine_control (
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs2_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_epc_out,
  output logic       set_cause_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       stall_out
);

`ifdef MSRV32_WFI_EN
  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_OPERATING   = 3'd1,
    ST_TRAP_TAKEN  = 3'd2,
    ST_TRAP_RETURN = 3'd3,
    ST_WFI         = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RESET       = 2'd0,
    ST_OPERATING   = 2'd1,
    ST_TRAP_TAKEN  = 2'd2,
    ST_TRAP_RETURN = 2'd3
  } state_t;
`endif

  // r_state is the debug-visible FSM state (enum-typed for waveform/probe binding).
  state_t     r_state;
  state_t     w_next_state;
  logic       r_i_or_e;
  logic [3:0] r_cause;
  logic       w_load_cause;
  logic       w_next_i_or_e;
  logic [3:0] w_next_cause;

  // SYSTEM instruction decode
  logic w_is_system;
  logic w_ecall;
  logic w_ebreak;
  logic w_mret;
  assign w_is_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000);
  assign w_ecall     = w_is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00000);
  assign w_ebreak    = w_is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00001);
  assign w_mret      = w_is_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);
`ifdef MSRV32_WFI_EN
  logic w_wfi;
  assign w_wfi       = w_is_system && (funct7_in == 7'b0001000) && (rs2_addr_in == 5'b00101);
`endif

  // Trap conditions; w_irq_pending ignores the global enable (used for WFI wake-up)
  logic w_irq_pending;
  logic w_interrupt;
  logic w_exception;
  assign w_irq_pending = (meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in);
  assign w_interrupt   = mie_in & w_irq_pending;
  assign w_exception   = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
                         misaligned_store_in | w_ecall | w_ebreak;

  // Cause encoders, highest priority source first
  logic [3:0] w_int_cause;
  logic [3:0] w_exc_cause;
  always_comb begin
    w_int_cause = 4'd7;
    if (meie_in & meip_in)      w_int_cause = 4'd11;
    else if (msie_in & msip_in) w_int_cause = 4'd3;

    w_exc_cause = 4'd6;
    if (misaligned_instr_in)     w_exc_cause = 4'd0;
    else if (illegal_instr_in)   w_exc_cause = 4'd2;
    else if (w_ebreak)           w_exc_cause = 4'd3;
    else if (w_ecall)            w_exc_cause = 4'd11;
    else if (misaligned_load_in) w_exc_cause = 4'd4;
  end

  // State register and trap-cause registers (cause loaded only on trap entry)
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state  <= ST_RESET;
      r_i_or_e <= 1'b0;
      r_cause  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (w_load_cause) begin
        r_i_or_e <= w_next_i_or_e;
        r_cause  <= w_next_cause;
      end
    end
  end

  // Next-state logic; trap inputs are only acted on in OPERATING (and WFI wake-up)
  always_comb begin
    w_next_state  = r_state;
    w_load_cause  = 1'b0;
    w_next_i_or_e = r_i_or_e;
    w_next_cause  = r_cause;
    case (r_state)
      ST_RESET: w_next_state = ST_OPERATING;
      ST_OPERATING: begin
        if (w_interrupt) begin
          w_next_state  = ST_TRAP_TAKEN;
          w_load_cause  = 1'b1;
          w_next_i_or_e = 1'b1;
          w_next_cause  = w_int_cause;
        end else if (w_exception) begin
          w_next_state  = ST_TRAP_TAKEN;
          w_load_cause  = 1'b1;
          w_next_i_or_e = 1'b0;
          w_next_cause  = w_exc_cause;
        end else if (w_mret) begin
          w_next_state = ST_TRAP_RETURN;
`ifdef MSRV32_WFI_EN
        end else if (w_wfi) begin
          w_next_state = ST_WFI;
`endif
        end
      end
      ST_TRAP_TAKEN:  w_next_state = ST_OPERATING;
      ST_TRAP_RETURN: w_next_state = ST_OPERATING;
`ifdef MSRV32_WFI_EN
      ST_WFI: begin
        if (w_irq_pending) begin
          if (mie_in) begin
            w_next_state  = ST_TRAP_TAKEN;
            w_load_cause  = 1'b1;
            w_next_i_or_e = 1'b1;
            w_next_cause  = w_int_cause;
          end else begin
            w_next_state = ST_OPERATING;
          end
        end
      end
`endif
      default: w_next_state = ST_RESET;
    endcase
  end

  // Moore strobes decoded from the state register
  always_comb begin
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    pc_src_out      = 2'b11;
    flush_out       = 1'b0;
    stall_out       = 1'b0;
    case (r_state)
      ST_RESET: begin
        pc_src_out = 2'b00;
        flush_out  = 1'b1;
      end
      ST_OPERATING: begin
        instret_inc_out = (w_next_state == ST_OPERATING);
      end
      ST_TRAP_TAKEN: begin
        set_epc_out   = 1'b1;
        set_cause_out = 1'b1;
        mie_clear_out = 1'b1;
        flush_out     = 1'b1;
        pc_src_out    = 2'b10;
      end
      ST_TRAP_RETURN: begin
        mie_set_out = 1'b1;
        flush_out   = 1'b1;
        pc_src_out  = 2'b01;
      end
`ifdef MSRV32_WFI_EN
      ST_WFI: stall_out = 1'b1;
`endif
      default: begin
        pc_src_out = 2'b00;
        flush_out  = 1'b1;
      end
    endcase
  end

  assign i_or_e_out = r_i_or_e;
  assign cause_out  = r_cause;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Self-checking bench for msrv32_machine_control.
// Outputs are packed into one 14-bit word:
// {i_or_e, cause[3:0], set_epc, set_cause, mie_clear, mie_set, instret, pc_src[1:0], flush, stall}.
// Build with +define+MSRV32_WFI_EN to exercise the WFI state.
module tb_msrv32_machine_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       illegal, mis_instr, mis_load, mis_store;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs2;
  logic       mie, meie, mtie, msie, meip, mtip, msip;
  logic       i_or_e;
  logic [3:0] cause;
  logic       set_epc, set_cause, mie_clear, mie_set, instret, flush, stall;
  logic [1:0] pc_src;
  logic [13:0] w_obs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  string       name_q[$];

  // bench model of the held trap cause
  logic       m_ie    = 1'b0;
  logic [3:0] m_cause = 4'd0;

  msrv32_machine_control dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .illegal_instr_in     (illegal),
    .misaligned_instr_in  (mis_instr),
    .misaligned_load_in   (mis_load),
    .misaligned_store_in  (mis_store),
    .opcode_6_to_2_in     (opcode),
    .funct3_in            (funct3),
    .funct7_in            (funct7),
    .rs2_addr_in          (rs2),
    .mie_in               (mie),
    .meie_in              (meie),
    .mtie_in              (mtie),
    .msie_in              (msie),
    .meip_in              (meip),
    .mtip_in              (mtip),
    .msip_in              (msip),
    .i_or_e_out           (i_or_e),
    .cause_out            (cause),
    .set_epc_out          (set_epc),
    .set_cause_out        (set_cause),
    .mie_clear_out        (mie_clear),
    .mie_set_out          (mie_set),
    .instret_inc_out      (instret),
    .pc_src_out           (pc_src),
    .flush_out            (flush),
    .stall_out            (stall)
  );

  assign w_obs = {i_or_e, cause, set_epc, set_cause, mie_clear, mie_set, instret, pc_src, flush, stall};

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] mk(input logic ie, input logic [3:0] c, input logic epc,
                                     input logic scause, input logic mclr, input logic mset,
                                     input logic inst, input logic [1:0] pc, input logic fl,
                                     input logic st);
    return {ie, c, epc, scause, mclr, mset, inst, pc, fl, st};
  endfunction
  function automatic logic [13:0] e_rst();  return mk(1'b0, 4'd0, 0, 0, 0, 0, 0, 2'b00, 1, 0); endfunction
  function automatic logic [13:0] e_op(input logic inst); return mk(m_ie, m_cause, 0, 0, 0, 0, inst, 2'b11, 0, 0); endfunction
  function automatic logic [13:0] e_trap(); return mk(m_ie, m_cause, 1, 1, 1, 0, 0, 2'b10, 1, 0); endfunction
  function automatic logic [13:0] e_ret();  return mk(m_ie, m_cause, 0, 0, 0, 1, 0, 2'b01, 1, 0); endfunction
  function automatic logic [13:0] e_wfi();  return mk(m_ie, m_cause, 0, 0, 0, 0, 0, 2'b11, 0, 1); endfunction

  // driver tasks
  task automatic set_idle();
    illegal = 0; mis_instr = 0; mis_load = 0; mis_store = 0;
    opcode = 5'b01100; funct3 = 3'b000; funct7 = 7'd0; rs2 = 5'd0;
    mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
  endtask

  task automatic set_sys(input logic [6:0] f7, input logic [4:0] r2);
    opcode = 5'b11100; funct3 = 3'b000; funct7 = f7; rs2 = r2;
  endtask

  // push expectation for the current cycle, sample at negedge, advance to posedge+1
  task automatic step(input string nm, input logic [13:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    obs_q.push_back(w_obs);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e, o; string nm;
    rst = 1; set_idle();
    repeat (2) @(posedge clk);
    #1;
    step("reset_hold", e_rst());
    m_ie = 0; m_cause = 0;
    rst = 0;
    step("reset_release", e_rst());
    step("first_operating", e_op(1));
    step("idle_operating", e_op(1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, o, e); end
    end
  endtask

  task automatic test_ecall();
    logic [13:0] e, o; string nm;
    set_sys(7'b0000000, 5'b00000);
    step("ecall_decide", e_op(0));
    set_idle();
    m_ie = 0; m_cause = 4'd11;
    step("ecall_trap", e_trap());
    step("ecall_back", e_op(1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, o, e); end
    end
  endtask

  task automatic test_mret();
    logic [13:0] e, o; string nm;
    set_sys(7'b0011000, 5'b00010);
    step("mret_decide", e_op(0));
    set_idle();
    step("mret_return", e_ret());
    step("mret_back", e_op(1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, o, e); end
    end
  endtask

  // directed priority table: each row gives inputs and the expected trap result
  task automatic test_priority();
    logic [13:0] e, o; string nm;
    logic        t_ie; logic [3:0] t_c; logic t_ret;
    for (int i = 0; i < 11; i++) begin
      set_idle(); t_ret = 0; t_ie = 0; t_c = 0;
      case (i)
        0:  begin mie = 1; meie = 1; meip = 1; mtie = 1; mtip = 1; illegal = 1; t_ie = 1; t_c = 11; end
        1:  begin mie = 1; msie = 1; msip = 1; mtie = 1; mtip = 1; t_ie = 1; t_c = 3; end
        2:  begin mie = 1; mtie = 1; mtip = 1; t_ie = 1; t_c = 7; end
        3:  begin meie = 1; meip = 1; illegal = 1; mis_instr = 1; t_c = 0; end
        4:  begin illegal = 1; mis_load = 1; set_sys(7'd0, 5'd0); t_c = 2; end
        5:  begin mis_load = 1; mis_store = 1; set_sys(7'd0, 5'd1); t_c = 3; end
        6:  begin mis_store = 1; set_sys(7'd0, 5'd0); t_c = 11; end
        7:  begin mis_load = 1; mis_store = 1; t_c = 4; end
        8:  begin mis_store = 1; t_c = 6; end
        9:  begin illegal = 1; set_sys(7'b0011000, 5'b00010); t_c = 2; end
        default: begin mie = 1; msie = 1; msip = 1; set_sys(7'b0011000, 5'b00010); t_ie = 1; t_c = 3; end
      endcase
      step($sformatf("prio%0d_decide", i), e_op(0));
      set_idle();
      if (!t_ret) begin m_ie = t_ie; m_cause = t_c; end
      step($sformatf("prio%0d_trap", i), e_trap());
      step($sformatf("prio%0d_back", i), e_op(1));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, o, e); end
    end
  endtask

  // random events from OPERATING; junk inputs during TRAP states must be ignored
  task automatic test_random();
    logic [13:0] e, o; string nm;
    int sel; logic irq, exc, ret; logic t_ie; logic [3:0] t_c;
    for (int i = 0; i < 40; i++) begin
      set_idle();
      illegal   = ($urandom_range(0, 4) == 0);
      mis_instr = ($urandom_range(0, 5) == 0);
      mis_load  = ($urandom_range(0, 4) == 0);
      mis_store = ($urandom_range(0, 4) == 0);
      mie = $urandom_range(0, 1); meie = $urandom_range(0, 1); meip = $urandom_range(0, 1);
      msie = $urandom_range(0, 1); msip = $urandom_range(0, 1);
      mtie = $urandom_range(0, 1); mtip = $urandom_range(0, 1);
      sel = $urandom_range(0, 4);
      case (sel)
        1: set_sys(7'd0, 5'd0);
        2: set_sys(7'd0, 5'd1);
        3: set_sys(7'b0011000, 5'b00010);
        4: set_sys(7'd0, 5'd2);
        default: ;
      endcase
      irq = mie & ((meie & meip) | (msie & msip) | (mtie & mtip));
      exc = illegal | mis_instr | mis_load | mis_store | (sel == 1) | (sel == 2);
      ret = (sel == 3);
      t_ie = 0; t_c = 0;
      if (irq) begin
        t_ie = 1;
        if (meie & meip)      t_c = 11;
        else if (msie & msip) t_c = 3;
        else                  t_c = 7;
      end else if (exc) begin
        if (mis_instr)        t_c = 0;
        else if (illegal)     t_c = 2;
        else if (sel == 2)    t_c = 3;
        else if (sel == 1)    t_c = 11;
        else if (mis_load)    t_c = 4;
        else                  t_c = 6;
      end
      step($sformatf("rand%0d_decide", i), e_op(!(irq | exc | ret)));
      set_idle();
      if (irq | exc | ret) begin
        illegal = 1; mie = 1; meie = 1; meip = 1; set_sys(7'd0, 5'd0);
        if (irq | exc) begin
          m_ie = t_ie; m_cause = t_c;
          step($sformatf("rand%0d_trap", i), e_trap());
        end else begin
          step($sformatf("rand%0d_ret", i), e_ret());
        end
        set_idle();
      end
      step($sformatf("rand%0d_after", i), e_op(1));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, o, e); end
    end
  endtask

  task automatic test_wfi();
    logic [13:0] e, o; string nm;
`ifdef MSRV32_WFI_EN
    set_sys(7'b0001000, 5'b00101);
    step("wfi_decide", e_op(0));
    set_idle();
    for (int i = 0; i < 5; i++) step("wfi_stall", e_wfi());
    mie = 1; msie = 1; msip = 1;
    step("wfi_wake_irq", e_wfi());
    set_idle();
    m_ie = 1; m_cause = 3;
    step("wfi_trap", e_trap());
    step("wfi_trap_back", e_op(1));
    set_sys(7'b0001000, 5'b00101);
    step("wfi2_decide", e_op(0));
    set_idle();
    mtip = 1; mie = 1;
    for (int i = 0; i < 5; i++) step("wfi2_stall_disabled_pend", e_wfi());
    set_idle();
    msie = 1; msip = 1;
    step("wfi2_wake_nomie", e_wfi());
    set_idle();
    step("wfi2_resume", e_op(1));
    step("wfi2_idle", e_op(1));
`else
    set_sys(7'b0001000, 5'b00101);
    step("wfi_nop", e_op(1));
    set_idle();
    step("wfi_nop_after", e_op(1));
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, o, e); end
    end
  endtask

  // reset applied mid TRAP_TAKEN must clear strobes and cause without a clock edge
  task automatic test_reset_mid_trap();
    logic [13:0] e, o; string nm;
    set_sys(7'd0, 5'd1);
    step("midrst_decide", e_op(0));
    set_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, o, e); end
    end
    m_ie = 0; m_cause = 3;
    @(negedge clk);
    n_checks++;
    if (w_obs !== e_trap()) begin
      n_fail++; $display("FAIL midrst_trap: got %h expected %h", w_obs, e_trap());
    end
    #2 rst = 1;
    #1;
    m_ie = 0; m_cause = 0;
    n_checks++;
    if (w_obs !== e_rst()) begin
      n_fail++; $display("FAIL midrst_async: got %h expected %h", w_obs, e_rst());
    end
    @(posedge clk);
    #1;
    rst = 0;
    step("midrst_release", e_rst());
    step("midrst_operating", e_op(1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, o, e); end
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_ecall();
    test_mret();
    test_priority();
    test_random();
    test_wfi();
    test_reset_mid_trap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
